// File: rtl/mem_write_tracer_if.sv
// Store-trace drain channel: show-ahead head entry plus valid/ready handshake.
// The tracer drives the head entry (master); the consumer drives out_ready (slave).
interface mem_write_tracer_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_adr;
   logic [31:0] out_data;
   logic [31:0] out_pc;

   modport master (output out_valid, output out_adr, output out_data, output out_pc,
                   input  out_ready);
   modport slave  (input  out_valid, input  out_adr, input  out_data, input  out_pc,
                   output out_ready);
endinterface

// File: rtl/mem_write_tracer.sv
// Captures data-memory stores from the MIPS top into a show-ahead FIFO that a
// consumer drains through a valid/ready channel. An address filter selects the
// logged stores; stores dropped on a full FIFO are counted (saturating).
module mem_write_tracer #(
   parameter int          DEPTH       = 16,
   parameter int          PTR_W       = 4,
   parameter logic [31:0] FILTER_BASE = 32'h0,
   parameter logic [31:0] FILTER_MASK = 32'h0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 memwrite,
   input  logic [31:0]          dataadr,
   input  logic [31:0]          writedata,
   input  logic [31:0]          pc,
   mem_write_tracer_if.master   trace,
   output logic [PTR_W:0]       count,
   output logic                 full,
   output logic                 empty,
   output logic [15:0]          overflow_cnt
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   // Drop counter sticks at all-ones instead of wrapping back to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [95:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             hit;
   logic             push;
   logic             pop;
   logic             valid;

   assign valid = (count != '0);
   assign empty = !valid;
   assign full  = (count == FULL_CNT);
   assign hit   = enable & memwrite &
                  ((dataadr & FILTER_MASK) == (FILTER_BASE & FILTER_MASK));
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign pop   = valid & trace.out_ready;
   assign push  = hit & (!full | pop);

   assign trace.out_valid = valid;
   assign {trace.out_adr, trace.out_data, trace.out_pc} = mem[rd_ptr];

   // Storage write; never written during reset or on a flush cycle.
   always_ff @(posedge clk) begin
      if (!reset && !clear && push)
         mem[wr_ptr] <= {dataadr, writedata, pc};
   end

   // Pointers, occupancy and drop counter; flush has priority over push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_cnt <= '0;
      end else if (clear) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (pop && !push)
            count <= count - (PTR_W+1)'(1);
         if (hit && !push)
            overflow_cnt <= sat_inc16(overflow_cnt);
      end
   end

endmodule
